spi_slave_rx: RTL
=================

Name: spi_slave_rx

Overview:
- SPI receive stage that sits directly downstream of the team's SPI master transmitter and consumes its cs/sclk/mosi lines.
- Oversamples the serial lines on the system clock, deserializes MSB-first words, and presents each complete word on a single-entry valid/ready output register.
- Flags overrun (word lost because the consumer stalled) and framing errors (cs released mid-word).

Parameters:
- DATA_W, 8, bits per word; range 2..32.
- SYNC_STAGES, 2, synchronizer depth on sclk/cs/mosi; range 1..3.
- SAMPLE_EDGE, 0, 0 = sample mosi on sclk falling edge, 1 = on rising edge.
- SKIP_EDGES, 0, sample edges ignored at the start of each frame (preamble clocks); range 0..3.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- sclk  in  1  serial clock from master; idle low
- cs  in  1  chip select, active low
- mosi  in  1  serial data, MSB first
- rx_data  out  DATA_W  received word
- rx_valid  out  1  rx_data holds an unconsumed word
- rx_ready  in  1  consumer accepts rx_data when rx_valid && rx_ready at a clk edge
- overrun  out  1  one-cycle pulse: completed word dropped
- frame_err  out  1  one-cycle pulse: cs rose with a partial word
- busy  out  1  high while state == SHIFT

Behaviour:
- Reset: rx_data=0, rx_valid=0, overrun=0, frame_err=0, busy=0, FSM=IDLE, bit counter=0, skip counter=0, shift register=0.
- Reset also forces the sync flops and previous-value registers to idle values: sclk=0, cs=1, mosi=0.
- Synchronizers: sclk, cs and mosi each pass through SYNC_STAGES flops with identical delay, so data stays aligned with its clock.
- Edge detect: compare each synchronized signal with a one-flop delayed copy.
- Sample edge: the sclk fall (SAMPLE_EDGE=0) or rise (SAMPLE_EDGE=1) of the synchronized sclk.
- FSM IDLE:
  - Wait for a synchronized cs falling edge, then load skip counter=SKIP_EDGES and bit counter=0, and go to SHIFT.
  - A cs held low through reset appears as a fresh falling edge and starts a frame.
- FSM SHIFT, on each sample edge:
  - If skip counter != 0, decrement it and discard the bit.
  - Otherwise shift the synchronized mosi into the LSB and increment the bit counter.
  - On the DATA_W-th bit, commit the word (shift contents plus the new bit), reset bit counter to 0 and stay in SHIFT; back-to-back words within one cs-low frame are supported.
- FSM SHIFT, on a synchronized cs rising edge:
  - Go to IDLE.
  - If bit counter != 0, pulse frame_err for one cycle and discard the partial word.
- Priority: a cs rise and a sample edge in the same cycle is handled as a cs rise only; the edge is ignored.
- Sample edges while in IDLE are ignored.
- Commit:
  - If rx_valid=0, or rx_valid && rx_ready in the same cycle: load rx_data and set rx_valid=1.
  - Otherwise pulse overrun for one cycle, drop the new word, and keep rx_data/rx_valid unchanged.
- Handshake:
  - rx_valid && rx_ready with no commit clears rx_valid at that edge.
  - rx_data is stable while rx_valid && !rx_ready.
  - rx_valid never deasserts without rx_ready.
- Latency: the raw sclk edge that carries the last bit is captured by sync stage 1 at clk edge k; rx_data/rx_valid update at edge k+SYNC_STAGES.
- Timing requirement: sclk high and low phases must each last at least 2 clk periods; otherwise behaviour is undefined.
- Reset mid-word: everything returns to reset values, the partial word is lost and no frame_err is generated.

Test Plan:
- DATA_W=8, sclk period 8 clk, cs low, mosi 0xA5, rx_ready=1 -> exactly one rx_valid cycle with rx_data=0xA5; overrun=0, frame_err=0; busy falls after cs rises.
- Single frame 0x3C then 0xC3 with rx_ready=0 -> rx_data=0x3C held valid, overrun pulses once at the second commit; raising rx_ready afterwards clears rx_valid and no 0xC3 appears.
- Two words 0x12, 0x34, rx_ready pulsed on the same edge as the second commit -> 0x12 consumed, rx_data=0x34 valid, no overrun.
- 5 bits clocked (10110), then cs rises -> frame_err pulses once, rx_valid stays 0; the next full frame 0x5A is received correctly.
- Reset asserted after 4 bits of 0xFF, then released, then frame 0x81 -> all outputs 0 during reset, then rx_data=0x81 with no frame_err.
- SKIP_EDGES=1, frame with one preamble sclk pulse plus 0x96; additionally toggle sclk while cs is high -> rx_data=0x96 only; edges outside cs-low produce no activity.

Source files
------------

// File: rtl/spi_slave_rx_if.sv
// Bundle of the serial lines and the word-level valid/ready output of spi_slave_rx.
// The master modport is the side that drives the SPI lines and consumes words.
interface spi_slave_rx_if #(
    parameter int DATA_W = 8
);
    logic              sclk;
    logic              cs;
    logic              mosi;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic              overrun;
    logic              frame_err;
    logic              busy;

    modport master (
        output sclk, cs, mosi, rx_ready,
        input  rx_data, rx_valid, overrun, frame_err, busy
    );

    modport slave (
        input  sclk, cs, mosi, rx_ready,
        output rx_data, rx_valid, overrun, frame_err, busy
    );
endinterface

// File: rtl/spi_slave_rx.sv
// Oversampling SPI receiver: synchronizes cs/sclk/mosi, deserializes MSB-first words
// and holds each one in a single-entry valid/ready register with overrun/framing flags.
module spi_slave_rx #(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2,
    parameter bit SAMPLE_EDGE = 1'b0,
    parameter int SKIP_EDGES  = 0
) (
    input  logic          clk,
    input  logic          rst,
    spi_slave_rx_if.slave bus
);
    localparam int CNT_W = $clog2(DATA_W);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic                   r_sclk_prev;
    logic                   r_cs_prev;

    // Chains include the raw input at bit 0 so any depth (including 1) shifts uniformly.
    logic [SYNC_STAGES:0]   w_sclk_chain;
    logic [SYNC_STAGES:0]   w_cs_chain;
    logic [SYNC_STAGES:0]   w_mosi_chain;

    logic                   w_sclk_s;
    logic                   w_cs_s;
    logic                   w_mosi_s;
    logic                   w_sample;
    logic                   w_cs_fall;
    logic                   w_cs_rise;
    logic [DATA_W-1:0]      w_word;

    state_t                 r_state;
    logic [CNT_W-1:0]       r_bit_cnt;
    logic [1:0]             r_skip_cnt;
    logic [DATA_W-1:0]      r_shift;
    logic [DATA_W-1:0]      r_rx_data;
    logic                   r_rx_valid;
    logic                   r_overrun;
    logic                   r_frame_err;
    logic                   r_busy;

    assign w_sclk_chain = {r_sclk_sync, bus.sclk};
    assign w_cs_chain   = {r_cs_sync, bus.cs};
    assign w_mosi_chain = {r_mosi_sync, bus.mosi};

    assign w_sclk_s  = r_sclk_sync[SYNC_STAGES-1];
    assign w_cs_s    = r_cs_sync[SYNC_STAGES-1];
    assign w_mosi_s  = r_mosi_sync[SYNC_STAGES-1];

    assign w_sample  = SAMPLE_EDGE ? (w_sclk_s & ~r_sclk_prev) : (~w_sclk_s & r_sclk_prev);
    assign w_cs_fall = ~w_cs_s & r_cs_prev;
    assign w_cs_rise = w_cs_s & ~r_cs_prev;
    assign w_word    = {r_shift[DATA_W-2:0], w_mosi_s};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sclk_sync <= '0;
            r_cs_sync   <= '1;
            r_mosi_sync <= '0;
            r_sclk_prev <= 1'b0;
            r_cs_prev   <= 1'b1;
        end else begin
            r_sclk_sync <= w_sclk_chain[SYNC_STAGES-1:0];
            r_cs_sync   <= w_cs_chain[SYNC_STAGES-1:0];
            r_mosi_sync <= w_mosi_chain[SYNC_STAGES-1:0];
            r_sclk_prev <= w_sclk_s;
            r_cs_prev   <= w_cs_s;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_bit_cnt   <= '0;
            r_skip_cnt  <= '0;
            r_shift     <= '0;
            r_rx_data   <= '0;
            r_rx_valid  <= 1'b0;
            r_overrun   <= 1'b0;
            r_frame_err <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_overrun   <= 1'b0;
            r_frame_err <= 1'b0;
            if (r_rx_valid && bus.rx_ready) begin
                r_rx_valid <= 1'b0;
            end
            case (r_state)
                IDLE: begin
                    if (w_cs_fall) begin
                        r_skip_cnt <= 2'(SKIP_EDGES);
                        r_bit_cnt  <= '0;
                        r_state    <= SHIFT;
                        r_busy     <= 1'b1;
                    end
                end
                SHIFT: begin
                    // A cs rise wins over a coincident sample edge.
                    if (w_cs_rise) begin
                        r_state   <= IDLE;
                        r_busy    <= 1'b0;
                        r_bit_cnt <= '0;
                        if (r_bit_cnt != '0) begin
                            r_frame_err <= 1'b1;
                        end
                    end else if (w_sample) begin
                        if (r_skip_cnt != '0) begin
                            r_skip_cnt <= r_skip_cnt - 2'd1;
                        end else begin
                            r_shift <= w_word;
                            if (r_bit_cnt == CNT_W'(DATA_W - 1)) begin
                                r_bit_cnt <= '0;
                                if (!r_rx_valid || bus.rx_ready) begin
                                    r_rx_data  <= w_word;
                                    r_rx_valid <= 1'b1;
                                end else begin
                                    r_overrun <= 1'b1;
                                end
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.rx_data   = r_rx_data;
    assign bus.rx_valid  = r_rx_valid;
    assign bus.overrun   = r_overrun;
    assign bus.frame_err = r_frame_err;
    assign bus.busy      = r_busy;
endmodule
